simon_input_checker: RTL

//  Player-side counterpart of the Simon sequence playback: after Simon finishes a round, walks the

---
 rtl/simon_input_checker_pkg.sv | 20 ++
 rtl/simon_input_checker_press_edge_detector.sv | 31 +++
 rtl/simon_input_checker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/simon_input_checker_pkg.sv
// Shared definitions for the Simon player-side input checker: FSM state encoding
// and default sizing. Optional feature macro: PLAYER_TIMEOUT_EN.
package simon_input_checker_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_PRESS,
      ST_WAIT_RELEASE,
      ST_FAIL
   } state_t;

   localparam int DEF_MAX_LEN = 32;
   localparam int DEF_IDX_W   = 5;

`ifdef PLAYER_TIMEOUT_EN
   localparam int DEF_TIMEOUT_CYCLES = 400;
`endif

endpackage

// File: rtl/simon_input_checker_press_edge_detector.sv
// Button edge detector: registers the held level and emits one-cycle rise/fall
// pulses plus the button number captured on the rising edge.
module press_edge_detector (
   input  logic       clk,
   input  logic       reset,
   input  logic       pressed,
   input  logic [1:0] num,
   output logic       rise,
   output logic       fall,
   output logic [1:0] rise_num
);

   logic       press_prev;
   logic [1:0] num_q;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         press_prev <= 1'b0;
         num_q      <= 2'd0;
      end else begin
         press_prev <= pressed;
         if (rise) num_q <= num;
      end
   end

   assign rise     = pressed & ~press_prev;
   assign fall     = ~pressed & press_prev;
   assign rise_num = rise ? num : num_q;

endmodule

// File: rtl/simon_input_checker.sv
// Simon input checker: walks the stored sequence and compares each player press.
// Optional macro PLAYER_TIMEOUT_EN adds a per-press timeout leading to game over.
module simon_input_checker
   import simon_input_checker_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int IDX_W   = DEF_IDX_W
`ifdef PLAYER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_check,
   input  logic [IDX_W:0]   seq_len,
   output logic [IDX_W-1:0] seq_rd_addr,
   input  logic [1:0]       seq_rd_data,
   input  logic [1:0]       player_num,
   input  logic             player_pressed,
   output logic             busy,
   output logic             round_ok,
   output logic             game_over,
   output logic [IDX_W-1:0] cur_idx
);

   localparam logic [IDX_W:0] MAX_LEN_W = MAX_LEN[IDX_W:0];

   state_t           state, state_nx;
   logic             rise, fall;
   logic [1:0]       rise_num;
   logic [1:0]       expected;
   logic [IDX_W:0]   len_q;
   logic [IDX_W:0]   idx_inc;
   logic             last_entry;
   logic             fetch_ph;
   logic             round_ok_q;

   press_edge_detector u_edge (
      .clk      (clk),
      .reset    (reset),
      .pressed  (player_pressed),
      .num      (player_num),
      .rise     (rise),
      .fall     (fall),
      .rise_num (rise_num)
   );

   // Index math is one bit wider than cur_idx so a full-length round never wraps.
   assign idx_inc    = {1'b0, cur_idx} + {{IDX_W{1'b0}}, 1'b1};
   assign last_entry = (idx_inc == len_q);

`ifdef PLAYER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt;

   // Counter is zero on every WAIT_PRESS entry and counts only while waiting for a press.
   always_ff @(posedge clk) begin
      if (reset || state != ST_WAIT_PRESS) tmo_cnt <= '0;
      else                                 tmo_cnt <= tmo_cnt + 1'b1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      // NOTE: default first, so no path through the case can infer a latch.
      state_nx = state;
      case (state)
         ST_IDLE:
            if (start_check && seq_len != '0) state_nx = ST_FETCH;
         ST_FETCH:
            if (fetch_ph) state_nx = ST_WAIT_PRESS;
         ST_WAIT_PRESS:
            if (rise)
               state_nx = (rise_num == expected) ? ST_WAIT_RELEASE : ST_FAIL;
`ifdef PLAYER_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST)
               state_nx = ST_FAIL;
`endif
         ST_WAIT_RELEASE:
            if (fall) state_nx = last_entry ? ST_IDLE : ST_FETCH;
         ST_FAIL:
            state_nx = ST_FAIL;
         default:
            state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q      <= '0;
         cur_idx    <= '0;
         expected   <= 2'd0;
         fetch_ph   <= 1'b0;
         round_ok_q <= 1'b0;
      end else begin
         round_ok_q <= 1'b0;
         fetch_ph   <= 1'b0;
         case (state)
            ST_IDLE:
               if (start_check) begin
                  if (seq_len == '0) begin
                     round_ok_q <= 1'b1;
                  end else begin
                     len_q   <= (seq_len > MAX_LEN_W) ? MAX_LEN_W : seq_len;
                     cur_idx <= '0;
                  end
               end
            // First FETCH cycle presents the address; read data is valid in the second.
            ST_FETCH:
               if (fetch_ph) expected <= seq_rd_data;
               else          fetch_ph <= 1'b1;
            ST_WAIT_RELEASE:
               if (fall) begin
                  if (last_entry) round_ok_q <= 1'b1;
                  else            cur_idx    <= idx_inc[IDX_W-1:0];
               end
            default: ;
         endcase
      end
   end

   assign seq_rd_addr = cur_idx;

   always_comb begin
      busy      = (state == ST_FETCH) || (state == ST_WAIT_PRESS) ||
                  (state == ST_WAIT_RELEASE);
      game_over = (state == ST_FAIL);
      round_ok  = round_ok_q;
   end

endmodule
